// File: rtl/tristate_bus_pkg.sv
// Shared types and elaboration helpers for the tri-state bus controller.
package tristate_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_t;

    // Width of an index into n entries, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

    // Set of one-hot positions whose index has bit b set; drives the one-hot encoder.
    function automatic logic [15:0] idx_mask(input int b, input int n);
        logic [15:0] m;
        m = '0;
        for (int g = 0; g < n; g++) begin
            if (((g >> b) & 1) != 0) m = m | (16'(1) << g);
        end
        return m;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer, wrapping.
module rr_arbiter
    import tristate_bus_pkg::*;
#(
    parameter int N  = 4,
    parameter int OW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [OW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [OW-1:0] o_idx,
    output logic          o_valid
);

    logic [N-1:0] w_rot;
    logic [N-1:0] w_first;

    // Rotate so the pointer sits at bit 0, isolate the lowest set bit, rotate back.
    assign w_rot   = N'({i_req, i_req} >> i_ptr);
    assign w_first = w_rot & (~w_rot + N'(1));
    assign o_gnt   = N'(({w_first, w_first} << i_ptr) >> N);
    assign o_valid = |i_req;

    for (genvar b = 0; b < OW; b++) begin : g_enc
        localparam logic [15:0] MASK = idx_mask(b, N);
        assign o_idx[b] = |(o_gnt & MASK[N-1:0]);
    end

endmodule

// File: rtl/tristate_bus_ctrl.sv
// Round-robin owner of a shared tri-state bus with an enforced turnaround gap.
// Define BUS_HOLD_TIMEOUT_EN to bound each grant to MAX_HOLD cycles (adds timeout port).
module tristate_bus_ctrl
    import tristate_bus_pkg::*;
#(
    parameter int W        = 8,
    parameter int N        = 4,
    parameter int TURN_CYC = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            req,
    input  logic [N*W-1:0]          src_data,
    inout  wire  [W-1:0]            bus,
    output logic [W-1:0]            bus_rd,
    output logic [N-1:0]            grant,
    output logic                    busy,
    output logic [idx_width(N)-1:0] owner
`ifdef BUS_HOLD_TIMEOUT_EN
    ,
    output logic                    timeout
`endif
);

    localparam int OW = idx_width(N);
    localparam int TW = idx_width(TURN_CYC);

    if (N < 2 || N > 16 || W < 1 || TURN_CYC < 1 || MAX_HOLD < 1) begin : g_param_check
        $error("tristate_bus_ctrl: illegal parameter value");
    end

    state_t         r_state;
    logic [N-1:0]   r_grant;
    logic [OW-1:0]  r_owner;
    logic [OW-1:0]  r_ptr;
    logic           r_busy;
    logic [TW-1:0]  r_turn_cnt;
    logic [W-1:0]   r_bus_rd;
`ifdef BUS_HOLD_TIMEOUT_EN
    localparam int HW = idx_width(MAX_HOLD);
    logic [HW-1:0]  r_hold_cnt;
    logic           r_timeout;
`endif

    logic [N-1:0]   w_gnt;
    logic [OW-1:0]  w_idx;
    logic           w_valid;
    logic           w_drive;
    logic [W-1:0]   w_src [N];

    for (genvar g = 0; g < N; g++) begin : g_src
        assign w_src[g] = src_data[g*W +: W];
    end

    rr_arbiter #(.N(N), .OW(OW)) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_busy     <= 1'b0;
            r_turn_cnt <= '0;
`ifdef BUS_HOLD_TIMEOUT_EN
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
`ifdef BUS_HOLD_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_state <= DRIVE;
                        r_grant <= w_gnt;
                        r_owner <= w_idx;
                        r_ptr   <= OW'(rr_next(int'(w_idx), N));
                        r_busy  <= 1'b1;
`ifdef BUS_HOLD_TIMEOUT_EN
                        r_hold_cnt <= HW'(MAX_HOLD - 1);
`endif
                    end
                end
                DRIVE: begin
                    if (!req[r_owner]) begin
                        r_state    <= TURN;
                        r_grant    <= '0;
                        r_turn_cnt <= TW'(TURN_CYC - 1);
                    end
`ifdef BUS_HOLD_TIMEOUT_EN
                    else if (r_hold_cnt == '0) begin
                        // Pointer already sits past the owner, so it ends up last in line.
                        r_state    <= TURN;
                        r_grant    <= '0;
                        r_turn_cnt <= TW'(TURN_CYC - 1);
                        r_timeout  <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - HW'(1);
                    end
`endif
                end
                TURN: begin
                    if (r_turn_cnt == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_turn_cnt <= r_turn_cnt - TW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_bus_rd <= '0;
        else     r_bus_rd <= bus;
    end

    // Gating on the registered grant lets async reset release the bus immediately.
    assign w_drive = |r_grant;
    assign bus     = w_drive ? w_src[r_owner] : {W{1'bz}};

    assign bus_rd = r_bus_rd;
    assign grant  = r_grant;
    assign busy   = r_busy;
    assign owner  = r_owner;
`ifdef BUS_HOLD_TIMEOUT_EN
    assign timeout = r_timeout;
`endif

endmodule

// File: tb/tb_tristate_bus_ctrl.sv
// Bench for tristate_bus_ctrl: vector table, directed corner sequences, random traffic vs model.
// The bus is a pulled-up net, so an undriven bus reads as all ones.
module tb_tristate_bus_ctrl;

    localparam int W        = 8;
    localparam int N        = 4;
    localparam int TURN_CYC = 1;
    localparam int MAX_HOLD = 4;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] g;
        logic       b;
        logic [7:0] bus;
        logic [7:0] rd;
        logic [1:0] own;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [W-1:0]   src [N];
    logic [N*W-1:0] src_data;
    tri1  [W-1:0]   bus;
    logic [W-1:0]   bus_rd;
    logic [N-1:0]   grant;
    logic           busy;
    logic [1:0]     owner;
`ifdef BUS_HOLD_TIMEOUT_EN
    logic           timeout;
    int             m_hold;
    logic           m_to;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl [10];
    int   order [$];
    int   fair_exp [5] = '{0, 1, 2, 3, 0};
    int   hold;
    int   zc;

    // Reference model: who is driving, last owner, next-priority source, quiet cycles left.
    logic       m_act;
    logic [1:0] m_own;
    logic [1:0] m_ptr;
    int         m_quiet;
    logic [7:0] m_rd;

    assign src_data = {src[3], src[2], src[1], src[0]};

    always #5 clk = ~clk;

    tristate_bus_ctrl #(.W(W), .N(N), .TURN_CYC(TURN_CYC), .MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .src_data (src_data),
        .bus      (bus),
        .bus_rd   (bus_rd),
        .grant    (grant),
        .busy     (busy),
        .owner    (owner)
`ifdef BUS_HOLD_TIMEOUT_EN
        ,
        .timeout  (timeout)
`endif
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic [7:0] m_bus();
        return m_act ? src[m_own] : 8'hFF;
    endfunction

    task automatic model_reset();
        m_act = 1'b0; m_own = 2'd0; m_ptr = 2'd0; m_quiet = 0; m_rd = 8'h00;
`ifdef BUS_HOLD_TIMEOUT_EN
        m_hold = 0; m_to = 1'b0;
`endif
    endtask

    task automatic model_edge();
        logic [1:0] cand;
`ifdef BUS_HOLD_TIMEOUT_EN
        m_to = 1'b0;
`endif
        if (m_act) begin
            if (!req[m_own]) begin
                m_act = 1'b0; m_quiet = TURN_CYC;
            end
`ifdef BUS_HOLD_TIMEOUT_EN
            else if (m_hold == MAX_HOLD) begin
                m_act = 1'b0; m_quiet = TURN_CYC; m_to = 1'b1;
            end else begin
                m_hold++;
            end
`endif
        end else if (m_quiet > 0) begin
            m_quiet--;
        end else begin
            for (int k = 0; k < N; k++) begin
                cand = m_ptr + 2'(k);
                if (!m_act && req[cand]) begin
                    m_act = 1'b1; m_own = cand; m_ptr = cand + 2'd1;
`ifdef BUS_HOLD_TIMEOUT_EN
                    m_hold = 1;
`endif
                end
            end
        end
    endtask

    // Starts and ends on a falling edge; inputs are changed by the caller before calling.
    task automatic tick();
        logic [7:0] pre;
        #1;
        pre = m_bus();
        chk("bus_pre", bus, pre);
        @(posedge clk);
        model_edge();
        m_rd = pre;
        #1;
        chk("grant", 8'(grant), m_act ? 8'(4'b0001 << m_own) : 8'h00);
        chk("busy", 8'(busy), 8'(m_act || m_quiet > 0));
        chk("owner", 8'(owner), 8'(m_own));
        chk("bus", bus, m_bus());
        chk("bus_rd", bus_rd, m_rd);
        chk("onehot", 8'($onehot0(grant)), 8'd1);
`ifdef BUS_HOLD_TIMEOUT_EN
        chk("timeout", 8'(timeout), 8'(m_to));
`endif
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic rand_src();
        src[0] = 8'($urandom); src[1] = 8'($urandom);
        src[2] = 8'($urandom); src[3] = 8'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //             req      grant    busy  bus     bus_rd  owner
        tbl[0] = '{4'b0100, 4'b0100, 1'b1, 8'hA5, 8'hFF, 2'd2};
        tbl[1] = '{4'b0100, 4'b0100, 1'b1, 8'hA5, 8'hA5, 2'd2};
        tbl[2] = '{4'b0000, 4'b0000, 1'b1, 8'hFF, 8'hA5, 2'd2};
        tbl[3] = '{4'b0000, 4'b0000, 1'b0, 8'hFF, 8'hFF, 2'd2};
        tbl[4] = '{4'b0010, 4'b0010, 1'b1, 8'h22, 8'hFF, 2'd1};
        tbl[5] = '{4'b0011, 4'b0010, 1'b1, 8'h22, 8'h22, 2'd1};
        tbl[6] = '{4'b0001, 4'b0000, 1'b1, 8'hFF, 8'h22, 2'd1};
        tbl[7] = '{4'b0001, 4'b0000, 1'b0, 8'hFF, 8'hFF, 2'd1};
        tbl[8] = '{4'b0001, 4'b0001, 1'b1, 8'h33, 8'hFF, 2'd0};
        tbl[9] = '{4'b0000, 4'b0000, 1'b1, 8'hFF, 8'h33, 2'd0};

        // Reset held with every source requesting.
        rst = 1'b1;
        req = 4'b1111;
        rand_src();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 8'(grant), 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_bus", bus, 8'hFF);
        chk("rst_owner", 8'(owner), 8'h00);
        chk("rst_bus_rd", bus_rd, 8'h00);
        rst = 1'b0;
        tick();
        chk("first_grant", 8'(grant), 8'h01);

        // Table-driven single-owner and pointer sequence.
        do_reset();
        src[0] = 8'h33; src[1] = 8'h22; src[2] = 8'hA5; src[3] = 8'h11;
        for (int i = 0; i < 10; i++) begin
            req = tbl[i].req;
            tick();
            chk("tbl_grant", 8'(grant), 8'(tbl[i].g));
            chk("tbl_busy", 8'(busy), 8'(tbl[i].b));
            chk("tbl_bus", bus, tbl[i].bus);
            chk("tbl_bus_rd", bus_rd, tbl[i].rd);
            chk("tbl_owner", 8'(owner), 8'(tbl[i].own));
        end

        // Fairness: everyone requests, each owner lets go after three cycles.
        do_reset();
        req = 4'hF;
        hold = 0;
        zc = 0;
        for (int c = 0; c < 60 && order.size() < 5; c++) begin
            tick();
            req = 4'hF;
            if (grant != 4'h0) begin
                if (hold == 0) begin
                    if (order.size() > 0) chk("fair_gap", 8'(zc), 8'(TURN_CYC + 1));
                    order.push_back(int'(owner));
                    zc = 0;
                end
                hold++;
                if (hold == 3) req = 4'hF & ~grant;
            end else begin
                hold = 0;
                zc++;
            end
        end
        chk("fair_count", 8'(order.size()), 8'd5);
        for (int i = 0; i < order.size() && i < 5; i++)
            chk("fair_order", 8'(order[i]), 8'(fair_exp[i]));

        // Wrap-around: pointer at 3 with sources 3 and 0 requesting.
        do_reset();
        rand_src();
        req = 4'b0100;
        tick();
        req = 4'b0000;
        tick();
        tick();
        req = 4'b1001;
        tick();
        chk("wrap_first", 8'(grant), 8'h08);
        tick();
        req = 4'b0001;
        tick();
        tick();
        tick();
        chk("wrap_second", 8'(grant), 8'h01);

        // Asynchronous reset between edges while a source drives.
        do_reset();
        src[1] = 8'h3C;
        req = 4'b0010;
        tick();
        chk("arst_pre_bus", bus, 8'h3C);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_bus", bus, 8'hFF);
        chk("arst_grant", 8'(grant), 8'h00);
        chk("arst_busy", 8'(busy), 8'h00);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

`ifdef BUS_HOLD_TIMEOUT_EN
        // Stuck requester is cut off after MAX_HOLD cycles and the next one follows.
        do_reset();
        rand_src();
        req = 4'b0110;
        for (int i = 0; i < MAX_HOLD; i++) begin
            tick();
            chk("to_hold", 8'(grant), 8'h02);
        end
        tick();
        chk("to_pulse", 8'(timeout), 8'h01);
        chk("to_release", 8'(grant), 8'h00);
        tick();
        chk("to_pulse_end", 8'(timeout), 8'h00);
        tick();
        chk("to_next", 8'(grant), 8'h04);
`endif

        // Random traffic against the model.
        do_reset();
        req = 4'h0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            rand_src();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
